// File: rtl/alu_bit_serial_driver.sv
// Bit-serial initiator for an external combinational 1-bit ALU.
// Shifts a W-bit operand pair through LSB first and gathers F1..F4.
module alu_bit_serial_driver #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [W-1:0] cmd_a,
  input  logic [W-1:0] cmd_b,
  input  logic [1:0]   cmd_sel,
  output logic         alu_a,
  output logic         alu_b,
  output logic         alu_s1,
  output logic         alu_s0,
  input  logic         alu_f1,
  input  logic         alu_f2,
  input  logic         alu_f3,
  input  logic         alu_f4,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_f1,
  output logic [W-1:0] res_f2,
  output logic [W-1:0] res_f3,
  output logic [W-1:0] res_f4,
  output logic         busy
);

  localparam int IW = (W > 1) ? $clog2(W) : 1;
  localparam logic [IW-1:0] LAST = IW'(W - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [1:0]    sel_q, sel_d;
  logic [W-1:0]  r1_q, r1_d;
  logic [W-1:0]  r2_q, r2_d;
  logic [W-1:0]  r3_q, r3_d;
  logic [W-1:0]  r4_q, r4_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      r1_q    <= '0;
      r2_q    <= '0;
      r3_q    <= '0;
      r4_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      r3_q    <= r3_d;
      r4_q    <= r4_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    sel_d     = sel_q;
    r1_d      = r1_q;
    r2_d      = r2_q;
    r3_d      = r3_q;
    r4_d      = r4_q;
    cmd_ready = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b0;
    alu_a     = 1'b0;
    alu_b     = 1'b0;
    alu_s1    = 1'b0;
    alu_s0    = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          a_d     = cmd_a;
          b_d     = cmd_b;
          sel_d   = cmd_sel;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        busy   = 1'b1;
        alu_a  = a_q[idx_q];
        alu_b  = b_q[idx_q];
        alu_s1 = sel_q[1];
        alu_s0 = sel_q[0];
        r1_d[idx_q] = alu_f1;
        r2_d[idx_q] = alu_f2;
        r3_d[idx_q] = alu_f3;
        r4_d[idx_q] = alu_f4;
        // idx parks on the last bit rather than wrapping
        if (idx_q == LAST) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign res_f1 = r1_q;
  assign res_f2 = r2_q;
  assign res_f3 = r3_q;
  assign res_f4 = r4_q;

endmodule

// File: tb/tb_alu_bit_serial_driver.sv
// Random and directed checks of alu_bit_serial_driver against a
// vector-level model of the four ALU result words.
module tb_alu_bit_serial_driver;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [W-1:0] cmd_a = '0;
  logic [W-1:0] cmd_b = '0;
  logic [1:0]   cmd_sel = '0;
  logic         alu_a, alu_b, alu_s1, alu_s0;
  logic         alu_f1, alu_f2, alu_f3, alu_f4;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [W-1:0] res_f1, res_f2, res_f3, res_f4;
  logic         busy;

  int n_checks = 0;
  int n_errors = 0;

  alu_bit_serial_driver #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_sel   (cmd_sel),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_s1    (alu_s1),
    .alu_s0    (alu_s0),
    .alu_f1    (alu_f1),
    .alu_f2    (alu_f2),
    .alu_f3    (alu_f3),
    .alu_f4    (alu_f4),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_f1    (res_f1),
    .res_f2    (res_f2),
    .res_f3    (res_f3),
    .res_f4    (res_f4),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // external 1-bit ALU
  always_comb begin
    {alu_f1, alu_f2, alu_f3, alu_f4} = 4'b0000;
    case ({alu_s1, alu_s0})
      2'b00: {alu_f1, alu_f2, alu_f3, alu_f4} =
               {1'b0, 1'b1, alu_a, alu_b};
      2'b01: {alu_f1, alu_f2, alu_f3, alu_f4} =
               {alu_a & alu_b, alu_a & ~alu_b,
                ~alu_a & alu_b, ~alu_a & ~alu_b};
      2'b10: {alu_f1, alu_f2, alu_f3, alu_f4} =
               {~alu_a, ~alu_b, alu_a ^ alu_b, ~(alu_a ^ alu_b)};
      default: {alu_f1, alu_f2, alu_f3, alu_f4} =
               {alu_a | alu_b, alu_a | ~alu_b,
                ~alu_a | alu_b, ~alu_a | ~alu_b};
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4*W-1:0] model(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic [1:0] sel);
    logic [W-1:0] ones;
    ones = '1;
    case (sel)
      2'b00:   model = {{W{1'b0}}, ones, a, b};
      2'b01:   model = {a & b, a & ~b, ~a & b, ~a & ~b};
      2'b10:   model = {~a, ~b, a ^ b, ~(a ^ b)};
      default: model = {a | b, a | ~b, ~a | b, ~a | ~b};
    endcase
  endfunction

  task automatic check_res(input string tag, input logic [4*W-1:0] e);
    check({tag, "_r1"}, 32'(res_f1), 32'(e[4*W-1:3*W]));
    check({tag, "_r2"}, 32'(res_f2), 32'(e[3*W-1:2*W]));
    check({tag, "_r3"}, 32'(res_f3), 32'(e[2*W-1:W]));
    check({tag, "_r4"}, 32'(res_f4), 32'(e[W-1:0]));
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_rdy"}, 32'(cmd_ready), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_rv"}, 32'(res_valid), 32'd0);
    check({tag, "_alu"}, 32'({alu_a, alu_b, alu_s1, alu_s0}), 32'd0);
    check_res(tag, '0);
  endtask

  // handshake, then watch every serial bit and the DONE latency
  task automatic start_and_run(input string tag, input logic [W-1:0] a,
                               input logic [W-1:0] b,
                               input logic [1:0] sel);
    @(negedge clk);
    check({tag, "_idle_rdy"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_a = a;
    cmd_b = b;
    cmd_sel = sel;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_a = W'($urandom);
    cmd_b = W'($urandom);
    cmd_sel = 2'($urandom);
    for (int i = 0; i < W; i++) begin
      check({tag, "_bit"}, 32'({alu_a, alu_b, alu_s1, alu_s0, cmd_ready,
                                busy, res_valid}),
            32'({a[i], b[i], sel, 1'b0, 1'b1, 1'b0}));
      @(posedge clk);
      #1;
    end
    check({tag, "_lat_rv"}, 32'(res_valid), 32'd1);
    check({tag, "_done_alu"}, 32'({alu_a, alu_b, alu_s1, alu_s0}), 32'd0);
  endtask

  task automatic take_result(input string tag);
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    check({tag, "_taken"}, 32'({res_valid, busy, cmd_ready}), 32'b001);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [1:0] sel,
                        input logic [4*W-1:0] e);
    start_and_run(tag, a, b, sel);
    check_res(tag, e);
    take_result(tag);
    check_res({tag, "_kept"}, e);
  endtask

  initial begin
    logic [W-1:0] a, b;
    logic [1:0]   s;
    logic [4*W-1:0] e;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outs("reset");
    rst_n = 1'b1;

    run_op("t1", 4'b1010, 4'b0110, 2'b00, 16'b0000_1111_1010_0110);
    run_op("t2", 4'b1100, 4'b1010, 2'b01, 16'b1000_0100_0010_0001);
    run_op("t3", 4'b1100, 4'b1010, 2'b10, 16'b0011_0101_0110_1001);
    run_op("t4", 4'b1100, 4'b1010, 2'b11, 16'b1110_1101_1011_0111);

    // back-pressure in DONE while a new command is offered
    start_and_run("t5", 4'b1100, 4'b1010, 2'b01);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_a = 4'b0011;
    cmd_b = 4'b0101;
    cmd_sel = 2'b11;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("t5_hold", 32'({res_valid, cmd_ready, busy}), 32'b101);
      check_res("t5_hold", 16'b1000_0100_0010_0001);
    end
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    check("t5_idle", 32'({res_valid, cmd_ready, busy}), 32'b010);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    check("t5_accept", 32'({cmd_ready, busy}), 32'b01);
    repeat (W) @(posedge clk);
    #1;
    check("t5_rv2", 32'(res_valid), 32'd1);
    check_res("t5_new", model(4'b0011, 4'b0101, 2'b11));
    take_result("t5b");

    // reset in RUN at idx=2
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_a = 4'b1100;
    cmd_b = 4'b1010;
    cmd_sel = 2'b10;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("t6_bit2", 32'({alu_a, alu_b}), 32'b10);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_reset_outs("t6");
    for (int i = 0; i < W + 2; i++) begin
      @(posedge clk);
      #1;
      check("t6_norv", 32'({res_valid, busy}), 32'b00);
    end

    for (int n = 0; n < 40; n++) begin
      a = W'($urandom);
      b = W'($urandom);
      s = 2'($urandom);
      e = model(a, b, s);
      run_op("rnd", a, b, s, e);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got 1 want 0");
    $fatal(1, "timeout");
  end

endmodule
